vlsu_mask_sched: RTL and testbench
==================================

# vlsu_mask_sched

Mask-beat scheduler for the VLSU. It shares the single per-lane mask stream from the lanes (`mask_valid_i` / `mask_bits_i`) between the load unit and the store unit. Masked operations are served strictly in the order the control machine issued them. It queues one entry per masked operation and routes exactly the declared number of mask beats to the owning unit before moving to the next entry. It sits between the lane mask interface and the `mask_valid_i` / `mask_ready_o` ports of LoadUnit and StoreUnit. Mask bits bypass this block.

## Interface
- `NrLanes`, default 4: number of lanes sharing the mask stream.
- `Depth`, default 4: number of queued masked operations; power of two, ≥2.
- `MaxBeats`, default 256: maximum mask beats per operation.
- `BeatW`, localparam `$clog2(MaxBeats+1)`: width of a beat count.

Ports:
- `clk_i`  in  1  clock; the only clock.
- `rst_ni`  in  1  reset; synchronous, active-low.
- `op_valid_i`  in  1  control machine issues a masked op.
- `op_ready_o`  out  1  queue can accept an op.
- `op_is_load_i`  in  1  1 = load unit owns the op's beats, 0 = store unit.
- `op_beats_i`  in  BeatW  number of mask beats the op consumes.
- `mask_valid_i`  in  NrLanes  per-lane mask valid.
- `mask_ready_o`  out  NrLanes  per-lane mask ready; identical on all lanes.
- `ld_mask_valid_o`  out  1  mask beat offered to the load unit.
- `ld_mask_ready_i`  in  1  load unit accepts the beat.
- `st_mask_valid_o`  out  1  mask beat offered to the store unit.
- `st_mask_ready_i`  in  1  store unit accepts the beat.
- `busy_o`  out  1  queue non-empty.

## Operation
- Queue entry `{is_load, beats}` is written on `op_valid_i && op_ready_o`.
- An op with `op_beats_i == 0` is accepted but not written; it is dropped.
- `lanes_all` = AND of all bits of `mask_valid_i`. A beat is never consumed from a subset of lanes.
- Let `head` be the oldest entry and `hv` be queue non-empty:
  - `ld_mask_valid_o = hv & head.is_load & lanes_all`
  - `st_mask_valid_o = hv & ~head.is_load & lanes_all`
  - `tgt_rdy = head.is_load ? ld_mask_ready_i : st_mask_ready_i`
  - `mask_ready_o[l] = hv & lanes_all & tgt_rdy` for every lane `l`
- A beat fires when `hv & lanes_all & tgt_rdy`.
- Counter `cnt` (width BeatW) increments on each fired beat.
- When a fired beat has `cnt == head.beats-1`: pop the head and clear `cnt` to 0 in the same cycle.
- Two-state FSM:
  - IDLE (queue empty) goes to SERVE on any write.
  - SERVE goes to IDLE when the last beat of the last entry pops and no write happens in that cycle.
  - `busy_o = (state == SERVE)`.
- The non-owning unit never sees valid. Its ready input is ignored.
- Owner ready inputs must not depend on the block's valid outputs.

## Timing
- Reset values: all queue pointers 0, `cnt` 0, state IDLE, `op_ready_o` 1, all other outputs 0.
- All valid and ready outputs are combinational from registered state, `mask_valid_i` and the owner ready. There is zero cycle latency per beat.
- A newly written entry is visible at the head the cycle after the write. There is no flow-through when the queue is empty.
- `op_ready_o = (occupancy < Depth)`. It is registered-state only and does not depend on a pop in the same cycle. When full, a write and a pop cannot coincide.
- Simultaneous write and pop when not full: occupancy is unchanged and both pointers advance.
- Pointers wrap modulo Depth. full/empty is resolved with an extra pointer MSB.
- Back-to-back ops with different owners: the last beat of op A and the first beat of op B are in consecutive cycles. There is no bubble.
- Reset asserted mid-op: the queue is flushed and `cnt` is cleared at the next clock edge. Partially served beats are not replayed.

## Structure
- `vlsu_pkg` holds `mask_op_t` = `{logic is_load; logic [BeatW-1:0] beats;}`. It has no other new constants.
- One sub-module: `mask_op_fifo`. It is a plain registered FIFO (no flow-through) of `mask_op_t`, Depth entries, with synchronous active-low reset.
- Top level: counter, FSM and steering logic.
- VLSU instantiates this block. It drives ops from the control machine's meta handshake, using `vm == 0` ops only.

## Test plan
- After reset, `lanes_all` = 1 with no op queued: `mask_ready_o` = 0, both valids 0, `op_ready_o` = 1, `busy_o` = 0.
- Load op, 3 beats, `ld_mask_ready_i` = 1, lanes always valid: exactly 3 handshakes on cycles 1–3 after the write. Pop on the 3rd. `busy_o` falls the cycle after.
- Load op (2 beats) then store op (1 beat) queued: ld beats, ld beats, st beats on 3 consecutive cycles. `st_mask_valid_o` stays 0 until the ld op pops.
- Lanes 0–2 valid, lane 3 low for 5 cycles: `mask_ready_o` = 0 on all lanes and `cnt` is unchanged. The beat fires the cycle lane 3 rises.
- Fill 4 ops with the owner ready held 0: `op_ready_o` drops to 0. Release: after the first pop `op_ready_o` = 1 again. An op with `op_beats_i` = 0 is accepted without changing occupancy.
- `rst_ni` low mid-op (after 1 of 4 beats): the next cycle shows an empty queue and `cnt` = 0. A new 2-beat op then completes in exactly 2 beats.

Source files
------------

// File: rtl/vlsu_pkg.sv
// Shared VLSU types. The mask-op queue entry pairs the owning unit with the
// number of mask beats that unit will consume.
package vlsu_pkg;

  localparam int unsigned MaxMaskBeats = 256;
  localparam int unsigned MaskBeatW    = $clog2(MaxMaskBeats + 1);

  typedef struct packed {
    logic                 is_load;
    logic [MaskBeatW-1:0] beats;
  } mask_op_t;

endpackage

// File: rtl/mask_op_fifo.sv
// Plain registered FIFO of mask ops. A written entry becomes visible at the
// head one cycle later; full/empty are told apart by the extra pointer MSB.
module mask_op_fifo
  import vlsu_pkg::*;
#(
  parameter int unsigned Depth = 4,
  localparam int unsigned AW   = $clog2(Depth)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  mask_op_t      data_i,
  input  logic          pop_i,
  output mask_op_t      data_o,
  output logic          empty_o,
  output logic          full_o,
  output logic [AW:0]   level_o
);

  logic [AW:0] wptr, rptr;
  mask_op_t    mem [Depth];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push_i) wptr <= wptr + 1'b1;
      if (pop_i)  rptr <= rptr + 1'b1;
    end
  end

  // Storage needs no reset; the pointers alone define what is valid.
  always_ff @(posedge clk_i) begin
    if (push_i) mem[wptr[AW-1:0]] <= data_i;
  end

  assign data_o  = mem[rptr[AW-1:0]];
  assign empty_o = (wptr == rptr);
  assign full_o  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign level_o = wptr - rptr;

endmodule

// File: rtl/vlsu_mask_sched.sv
// Mask-beat scheduler: shares the lane mask stream between load and store
// units, serving queued masked ops in issue order, one full op at a time.
module vlsu_mask_sched
  import vlsu_pkg::*;
#(
  parameter int unsigned NrLanes  = 4,
  parameter int unsigned Depth    = 4,
  parameter int unsigned MaxBeats = 256,
  localparam int unsigned BeatW   = $clog2(MaxBeats + 1)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               op_valid_i,
  output logic               op_ready_o,
  input  logic               op_is_load_i,
  input  logic [BeatW-1:0]   op_beats_i,
  input  logic [NrLanes-1:0] mask_valid_i,
  output logic [NrLanes-1:0] mask_ready_o,
  output logic               ld_mask_valid_o,
  input  logic               ld_mask_ready_i,
  output logic               st_mask_valid_o,
  input  logic               st_mask_ready_i,
  output logic               busy_o
);

  localparam int unsigned LvlW = $clog2(Depth) + 1;

  localparam logic IDLE  = 1'b0;
  localparam logic SERVE = 1'b1;

  logic            state, state_nxt;
  logic [BeatW-1:0] cnt;
  mask_op_t        head, wr_op;
  logic            empty, full, hv;
  logic [LvlW-1:0] level;
  logic            lanes_all, tgt_rdy, fire, last, pop, wr;

  assign lanes_all = &mask_valid_i;
  assign hv        = ~empty;
  assign op_ready_o = ~full;

  // Zero-beat ops are handshaken but never occupy a slot.
  assign wr = op_valid_i & op_ready_o & (op_beats_i != '0);

  assign wr_op.is_load = op_is_load_i;
  assign wr_op.beats   = MaskBeatW'(op_beats_i);

  mask_op_fifo #(.Depth(Depth)) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (wr),
    .data_i  (wr_op),
    .pop_i   (pop),
    .data_o  (head),
    .empty_o (empty),
    .full_o  (full),
    .level_o (level)
  );

  assign tgt_rdy = head.is_load ? ld_mask_ready_i : st_mask_ready_i;
  assign fire    = hv & lanes_all & tgt_rdy;
  assign last    = (cnt == BeatW'(head.beats - 1'b1));
  assign pop     = fire & last;

  assign ld_mask_valid_o = hv &  head.is_load & lanes_all;
  assign st_mask_valid_o = hv & ~head.is_load & lanes_all;

  for (genvar l = 0; l < NrLanes; l++) begin : g_lane
    assign mask_ready_o[l] = fire;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni)   cnt <= '0;
    else if (pop)  cnt <= '0;
    else if (fire) cnt <= cnt + 1'b1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (wr) state_nxt = SERVE;
      SERVE: if (pop && !wr && level == LvlW'(1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_nxt;
  end

  assign busy_o = (state == SERVE);

endmodule

// File: tb/tb_vlsu_mask_sched.sv
// Scoreboarded bench for vlsu_mask_sched: each accepted op pushes its owner
// once per beat; every observed beat handshake pops and checks the owner.
module tb_vlsu_mask_sched;

  localparam int NL = 4;
  localparam int BW = 9;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          op_valid = 1'b0;
  logic          op_ready;
  logic          op_is_load = 1'b0;
  logic [BW-1:0] op_beats = '0;
  logic [NL-1:0] mask_valid = '1;
  logic [NL-1:0] mask_ready;
  logic          ld_v, st_v, busy;
  logic          ld_rdy = 1'b0;
  logic          st_rdy = 1'b0;

  int total = 0;
  int bad   = 0;
  int n_ld  = 0;
  int n_st  = 0;
  bit exp_q[$];

  always #5 clk = ~clk;

  vlsu_mask_sched #(.NrLanes(NL), .Depth(4), .MaxBeats(256)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .op_valid_i      (op_valid),
    .op_ready_o      (op_ready),
    .op_is_load_i    (op_is_load),
    .op_beats_i      (op_beats),
    .mask_valid_i    (mask_valid),
    .mask_ready_o    (mask_ready),
    .ld_mask_valid_o (ld_v),
    .ld_mask_ready_i (ld_rdy),
    .st_mask_valid_o (st_v),
    .st_mask_ready_i (st_rdy),
    .busy_o          (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Beat monitor: owner order against the scoreboard, lane-wide ready.
  always @(negedge clk) begin
    logic beat;
    if (rst_n) begin
      beat = (ld_v & ld_rdy) | (st_v & st_rdy);
      chk("excl", 32'(ld_v & st_v), 32'd0);
      chk("mrdy", 32'(mask_ready), 32'({NL{beat}}));
      if (beat) begin
        if (exp_q.size() == 0) chk("unexp_beat", 32'd1, 32'd0);
        else                   chk("owner", 32'(ld_v), 32'(exp_q.pop_front()));
        if (ld_v) n_ld++;
        else      n_st++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called just after a posedge; returns just after the accepting edge.
  task automatic issue(input bit ld, input int beats);
    int w = 0;
    op_valid   = 1'b1;
    op_is_load = ld;
    op_beats   = BW'(beats);
    @(negedge clk);
    while (!op_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!op_ready) chk("op_acc_timeout", 32'd0, 32'd1);
    @(posedge clk);
    if (op_ready) for (int i = 0; i < beats; i++) exp_q.push_back(ld);
    #1 op_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 100 && busy; i++) @(negedge clk);
    chk(tag, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, s0, nis;
    bit go, acc;

    // reset state with all lanes valid and both owners ready
    ld_rdy = 1'b1; st_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mrdy", 32'(mask_ready), 32'd0);
    chk("rst_ldv",  32'(ld_v), 32'd0);
    chk("rst_stv",  32'(st_v), 32'd0);
    chk("rst_oprdy", 32'(op_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);

    // single 3-beat load
    step();
    n0 = n_ld;
    issue(1'b1, 3);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("ld3_v", 32'(ld_v), 32'd1);
      chk("ld3_busy", 32'(busy), 32'd1);
    end
    @(negedge clk);
    chk("ld3_v_end", 32'(ld_v), 32'd0);
    chk("ld3_busy_end", 32'(busy), 32'd0);
    chk("ld3_cnt", 32'(n_ld - n0), 32'd3);

    // load(2) then store(1), no bubble between owners
    step();
    ld_rdy = 1'b0; st_rdy = 1'b0;
    issue(1'b1, 2);
    issue(1'b0, 1);
    ld_rdy = 1'b1; st_rdy = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("b2b_ldv", 32'(ld_v), 32'd1);
      chk("b2b_stv0", 32'(st_v), 32'd0);
    end
    @(negedge clk);
    chk("b2b_ldv0", 32'(ld_v), 32'd0);
    chk("b2b_stv", 32'(st_v), 32'd1);
    @(negedge clk);
    chk("b2b_busy", 32'(busy), 32'd0);

    // lane 3 late: no beat until all lanes valid
    step();
    mask_valid = 4'b0111;
    s0 = n_st;
    issue(1'b0, 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("lane_mrdy", 32'(mask_ready), 32'd0);
      chk("lane_stv", 32'(st_v), 32'd0);
      chk("lane_busy", 32'(busy), 32'd1);
    end
    step();
    mask_valid = '1;
    @(negedge clk);
    chk("lane_stv_up", 32'(st_v), 32'd1);
    chk("lane_mrdy_up", 32'(mask_ready), 32'hF);
    @(negedge clk);
    chk("lane_busy_end", 32'(busy), 32'd0);
    chk("lane_cnt", 32'(n_st - s0), 32'd1);

    // fill the queue, zero-beat op does not occupy a slot
    step();
    ld_rdy = 1'b0;
    n0 = n_ld;
    for (int k = 0; k < 3; k++) issue(1'b1, 1);
    issue(1'b1, 0);
    @(negedge clk);
    chk("zero_oprdy", 32'(op_ready), 32'd1);
    step();
    issue(1'b1, 1);
    @(negedge clk);
    chk("full_oprdy", 32'(op_ready), 32'd0);
    chk("full_busy", 32'(busy), 32'd1);
    step();
    ld_rdy = 1'b1;
    @(negedge clk);
    chk("full_oprdy_hold", 32'(op_ready), 32'd0);
    @(negedge clk);
    chk("full_oprdy_rel", 32'(op_ready), 32'd1);
    drain("full_drain");
    chk("full_cnt", 32'(n_ld - n0), 32'd4);

    // reset mid-op after one of four beats
    step();
    issue(1'b1, 4);
    @(negedge clk);
    chk("mid_ldv", 32'(ld_v), 32'd1);
    step();
    rst_n = 1'b0;
    step();
    @(negedge clk);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_ldv0", 32'(ld_v), 32'd0);
    chk("mid_mrdy", 32'(mask_ready), 32'd0);
    chk("mid_oprdy", 32'(op_ready), 32'd1);
    exp_q.delete();
    step();
    rst_n = 1'b1;
    n0 = n_ld;
    issue(1'b1, 2);
    repeat (4) @(negedge clk);
    chk("post_rst_cnt", 32'(n_ld - n0), 32'd2);
    chk("post_rst_busy", 32'(busy), 32'd0);

    // mixed traffic with random owner readiness and lane gaps
    step();
    nis = 0;
    for (int c = 0; c < 120; c++) begin
      ld_rdy     = 1'($urandom_range(0, 1));
      st_rdy     = 1'($urandom_range(0, 1));
      mask_valid = ($urandom_range(0, 4) == 0) ? NL'($urandom) : '1;
      go         = (nis < 12) && ($urandom_range(0, 2) == 0);
      op_valid   = go;
      op_is_load = 1'($urandom_range(0, 1));
      op_beats   = BW'($urandom_range(0, 5));
      @(negedge clk);
      acc = go && op_ready;
      @(posedge clk);
      if (acc) begin
        for (int i = 0; i < int'(op_beats); i++) exp_q.push_back(op_is_load);
        nis++;
      end
      #1;
    end
    op_valid = 1'b0;
    ld_rdy = 1'b1; st_rdy = 1'b1; mask_valid = '1;
    drain("rand_drain");
    @(negedge clk);
    chk("rand_left", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
